spi_slave_port: RTL and testbench
=================================

Name: spi_slave_port

Overview:
- Parametrised SPI slave front-end for the SoC debug/host link. Word width, SPI mode (CPOL/CPHA), bit order and synchroniser depth are configurable.
- All SPI pins are oversampled in the system clock domain (PLL output); the block never uses SPI_CLK as a clock.
- Delivers received words as one-cycle valid pulses and takes transmit words through a one-entry ready/valid buffer.
- Sits between the board SPI pins and the SoC bus bridge.

Parameters:
- WORD_W, 8: bits per SPI word (2..32).
- CPOL, 0: idle level of spi_clk.
- CPHA, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- MSB_FIRST, 1: 1 = MSB shifted first, 0 = LSB first.
- SYNC_STAGES, 2: synchroniser depth on spi_clk/spi_mosi/spi_ss (>=2).

Ports:
- clk  in  1  system clock (all logic, rising edge).
- rst  in  1  synchronous, active-high reset.
- spi_clk  in  1  SPI serial clock from host (asynchronous).
- spi_mosi  in  1  host-to-slave data.
- spi_ss  in  1  slave select, active low.
- spi_miso  out  1  slave-to-host data.
- rx_data  out  WORD_W  last complete received word.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- tx_data  in  WORD_W  word to send.
- tx_valid  in  1  tx_data offered.
- tx_ready  out  1  tx buffer empty, can accept.
- tx_underrun  out  1  one-cycle pulse: word load found buffer empty.
- busy  out  1  frame active (state ACTIVE).

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: spi_miso=0, rx_data=0, rx_valid=0, tx_ready=1, tx_underrun=0, busy=0. Synchronisers reset to sclk=CPOL, ss=1, mosi=0. Bit counter=0, tx buffer empty, state=IDLE.
- Synchronisation: each pin passes through SYNC_STAGES flops. Edges are detected by comparing the synchroniser output with a 1-flop history.
- Edge definitions: leading edge = synced sclk leaves CPOL; trailing edge = returns to CPOL. Sample edge = leading if CPHA=0, trailing if CPHA=1. Shift edge = the other edge.
- Timing constraint: the SPI clock must satisfy f_spi <= f_clk/4. Behaviour above this rate is undefined.
- FSM:
  - IDLE -> ACTIVE on synced ss falling edge.
  - ACTIVE -> IDLE on synced ss high.
  - WAIT_SS_HIGH is entered from reset if synced ss is low. It goes to IDLE once ss is seen high, so the block never joins a frame mid-stream.
- Word load (tx shift register <- tx buffer):
  - CPHA=0: load at SS fall and at the shift edge following each word's final sample.
  - CPHA=1: load at the first shift edge of each word.
  - All other shift edges advance the shift register by one bit in MSB_FIRST order.
- Empty buffer at load: shift register loads all-zeros and tx_underrun pulses for that cycle.
- Consumption: a load empties the buffer, so tx_ready=1 on the next cycle.
- MISO: spi_miso = current tx bit while ACTIVE, 0 otherwise.
- Sample edge: shift synced mosi into the rx shift register and increment the bit counter. At count WORD_W:
  - rx_data <= assembled word (MSB_FIRST order respected); rx_valid=1 for that single cycle.
  - Counter returns to 0.
  - rx_data holds until the next complete word. There is no backpressure.
- Latency: rx_valid rises SYNC_STAGES+1 clk cycles after the final sample edge reaches the pin synchroniser.
- tx handshake:
  - Accept when tx_valid && tx_ready. tx_ready is registered and derived from the empty flag only.
  - Load and accept in the same cycle: the load sees the buffer state at the start of the cycle. If that state is empty, the load underruns and the accepted word stays buffered for the next word.
  - tx_data must be held stable only during the accepting cycle.
- SS deassert mid-word: discard the partial rx word, with no rx_valid. Bit counter=0. A consumed tx word is not restored; the buffer is otherwise untouched.
- rst mid-frame: all state returns to reset values; WAIT_SS_HIGH rule applies.

Decomposition:
- Shared package spi_pkg holds:
  - spi_mode_t (2-bit {CPOL,CPHA}) and the MODE0..MODE3 constants;
  - SPI_WORD_W_DEFAULT=8;
  - SPI_SYNC_STAGES_DEFAULT=2.
- Sub-module sync_ff (parametrised depth and reset value, 1-bit). One instance each for spi_clk, spi_mosi and spi_ss.

Test Plan:
- Mode 0, WORD_W=8, MSB_FIRST: host sends 0xA5 while tx_data=0x3C preloaded -> rx_data=0xA5 with exactly one rx_valid pulse; host receives 0x3C; tx_ready re-asserts after the load.
- Mode 3, WORD_W=16, LSB_FIRST: two back-to-back words 0x1234, 0xBEEF; buffer refilled between them -> two rx_valid pulses with matching data; MISO returns both tx words; no tx_underrun.
- Empty tx buffer at frame start (mode 1) -> MISO shifts 0x00; tx_underrun pulses once; a word offered mid-frame is sent in the next word.
- SS deasserted after 5 of 8 bits -> no rx_valid, rx_data unchanged; the next full frame receives correctly.
- rst asserted mid-frame with SS held low -> outputs at reset values, busy=0 until SS goes high then low again; the following frame works.
- tx_valid coincides with the load cycle on an empty buffer -> underrun pulse that cycle; the word is held and sent in the following word.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared mode encodings, defaults and FSM state type for the SPI slave port.
package spi_pkg;

    typedef logic [1:0] spi_mode_t;  // {CPOL, CPHA}

    localparam spi_mode_t MODE0 = 2'b00;
    localparam spi_mode_t MODE1 = 2'b01;
    localparam spi_mode_t MODE2 = 2'b10;
    localparam spi_mode_t MODE3 = 2'b11;

    localparam int SPI_WORD_W_DEFAULT      = 8;
    localparam int SPI_SYNC_STAGES_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_WAIT_SS_HIGH
    } spi_state_t;

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchroniser with a configurable reset value.
module sync_ff #(
    parameter int DEPTH   = 2,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stages;

    always_ff @(posedge clk) begin
        if (rst) begin
            stages <= {DEPTH{RST_VAL}};
        end else begin
            stages <= {stages[DEPTH-2:0], d};
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/spi_slave_port.sv
// Oversampled SPI slave: pins are synchronised into clk, edges detected there,
// received words pulse out on rx_valid and transmit words come from a one-entry buffer.
module spi_slave_port
    import spi_pkg::*;
#(
    parameter int WORD_W      = SPI_WORD_W_DEFAULT,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    input  logic              spi_ss,
    output logic              spi_miso,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int CNT_W   = $clog2(WORD_W);
    localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);

    logic sclk_s, mosi_s, ss_s;
    logic sclk_d, ss_d;

    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(spi_clk), .q(sclk_s)
    );
    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(spi_mosi), .q(mosi_s)
    );
    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst(rst), .d(spi_ss), .q(ss_s)
    );

    spi_state_t        state;
    logic [FLUSH_W-1:0] flush_cnt;
    logic [CNT_W-1:0]   bit_cnt;
    logic [WORD_W-1:0]  rx_sr, tx_sr, tx_buf, rx_next, tx_word;
    logic               tx_full;
    logic leading, trailing, sample_edge, shift_edge, ss_fall, settled, in_frame, load, accept;

    always_comb begin
        leading     = (sclk_s != CPOL) && (sclk_d == CPOL);
        trailing    = (sclk_s == CPOL) && (sclk_d != CPOL);
        sample_edge = CPHA ? trailing : leading;
        shift_edge  = CPHA ? leading : trailing;
        ss_fall     = ss_d && !ss_s;
        settled     = (flush_cnt == FLUSH_W'(SYNC_STAGES));
        in_frame    = (state == ST_ACTIVE) && !ss_s;
        rx_next     = MSB_FIRST ? {rx_sr[WORD_W-2:0], mosi_s} : {mosi_s, rx_sr[WORD_W-1:1]};
        // A shift edge with the bit counter at zero is always the first shift of a word.
        load        = (in_frame && shift_edge && (bit_cnt == '0))
                    || (!CPHA && (state == ST_IDLE) && ss_fall);
        tx_word     = tx_full ? tx_buf : '0;
        accept      = tx_valid && tx_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_d      <= CPOL;
            ss_d        <= 1'b1;
            // Held here until the synchronisers have flushed, then left only once SS reads high.
            state       <= ST_WAIT_SS_HIGH;
            busy        <= 1'b0;
            flush_cnt   <= '0;
            bit_cnt     <= '0;
            rx_sr       <= '0;
            tx_sr       <= '0;
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            sclk_d      <= sclk_s;
            ss_d        <= ss_s;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            if (!settled) begin
                flush_cnt <= flush_cnt + FLUSH_W'(1);
            end

            case (state)
                ST_WAIT_SS_HIGH: begin
                    if (settled && ss_s) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (ss_fall) begin
                        state <= ST_ACTIVE;
                        busy  <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (ss_s) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        bit_cnt <= '0;
                    end else if (sample_edge) begin
                        rx_sr <= rx_next;
                        if (bit_cnt == CNT_W'(WORD_W - 1)) begin
                            bit_cnt  <= '0;
                            rx_data  <= rx_next;
                            rx_valid <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (load) begin
                tx_sr       <= tx_word;
                tx_full     <= 1'b0;
                tx_underrun <= !tx_full;
            end else if (in_frame && shift_edge) begin
                tx_sr <= MSB_FIRST ? {tx_sr[WORD_W-2:0], 1'b0} : {1'b0, tx_sr[WORD_W-1:1]};
            end

            // Accept after load so a same-cycle load sees the old (empty) buffer.
            if (accept) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end
        end
    end

    assign tx_ready = !tx_full;
    assign spi_miso = busy && (MSB_FIRST ? tx_sr[WORD_W-1] : tx_sr[0]);

endmodule

// File: tb/tb_spi_slave_port.sv
// Bench for spi_slave_port: three instances (mode0/8b/MSB, mode3/16b/LSB, mode1/8b/MSB)
// driven by a bit-level host and checked against a word-level buffer model.
module tb_spi_slave_port;

    localparam int N    = 3;
    localparam int HALF = 8;
    localparam int W_OF    [N] = '{8, 16, 8};
    localparam bit CPOL_OF [N] = '{1'b0, 1'b1, 1'b0};
    localparam bit CPHA_OF [N] = '{1'b0, 1'b1, 1'b1};
    localparam bit MSB_OF  [N] = '{1'b1, 1'b0, 1'b1};

    logic clk = 1'b0;
    logic rst;
    logic mosi;
    logic sclk [N];
    logic ss   [N];
    logic txv  [N];
    logic miso [N];
    logic rxv  [N];
    logic txr  [N];
    logic und  [N];
    logic bsy  [N];
    logic [7:0]  txd0, rxd0, txd2, rxd2;
    logic [15:0] txd1, rxd1;

    int checks = 0;
    int errors = 0;
    int und_cnt [N] = '{0, 0, 0};
    int rx_n = 0;
    logic [31:0] rx_at_pulse = '0;

    // Word-level model: one-entry buffer per instance, expected underruns and last rx word.
    logic [31:0] mbuf    [N];
    bit          mfull   [N];
    int          exp_und [N];
    logic [31:0] last_rx [N];
    logic [31:0] pend    [N];

    always #5 clk = ~clk;

    spi_slave_port #(.WORD_W(8), .CPOL(CPOL_OF[0]), .CPHA(CPHA_OF[0]), .MSB_FIRST(MSB_OF[0]), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .rst(rst), .spi_clk(sclk[0]), .spi_mosi(mosi), .spi_ss(ss[0]), .spi_miso(miso[0]),
        .rx_data(rxd0), .rx_valid(rxv[0]), .tx_data(txd0), .tx_valid(txv[0]), .tx_ready(txr[0]),
        .tx_underrun(und[0]), .busy(bsy[0]));

    spi_slave_port #(.WORD_W(16), .CPOL(CPOL_OF[1]), .CPHA(CPHA_OF[1]), .MSB_FIRST(MSB_OF[1]), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .rst(rst), .spi_clk(sclk[1]), .spi_mosi(mosi), .spi_ss(ss[1]), .spi_miso(miso[1]),
        .rx_data(rxd1), .rx_valid(rxv[1]), .tx_data(txd1), .tx_valid(txv[1]), .tx_ready(txr[1]),
        .tx_underrun(und[1]), .busy(bsy[1]));

    spi_slave_port #(.WORD_W(8), .CPOL(CPOL_OF[2]), .CPHA(CPHA_OF[2]), .MSB_FIRST(MSB_OF[2]), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .rst(rst), .spi_clk(sclk[2]), .spi_mosi(mosi), .spi_ss(ss[2]), .spi_miso(miso[2]),
        .rx_data(rxd2), .rx_valid(rxv[2]), .tx_data(txd2), .tx_valid(txv[2]), .tx_ready(txr[2]),
        .tx_underrun(und[2]), .busy(bsy[2]));

    function automatic logic [31:0] rxd_of(input int i);
        case (i)
            0:       return {24'h0, rxd0};
            1:       return {16'h0, rxd1};
            default: return {24'h0, rxd2};
        endcase
    endfunction

    function automatic logic [31:0] mask(input int i, input logic [31:0] w);
        return (W_OF[i] == 32) ? w : (w & ((32'h1 << W_OF[i]) - 32'h1));
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (und[i] === 1'b1) und_cnt[i]++;
            if (rxv[i] === 1'b1) begin
                rx_n++;
                rx_at_pulse = rxd_of(i);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_txd(input int i, input logic [31:0] w);
        case (i)
            0:       txd0 = w[7:0];
            1:       txd1 = w[15:0];
            default: txd2 = w[7:0];
        endcase
    endtask

    task automatic model_load(input int i, output logic [31:0] w);
        if (mfull[i]) begin
            w        = mbuf[i];
            mfull[i] = 1'b0;
        end else begin
            w = '0;
            exp_und[i]++;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mfull[i]   = 1'b0;
            last_rx[i] = '0;
        end
    endtask

    task automatic offer(input int i, input logic [31:0] w);
        chk("tx_ready", {31'b0, txr[i]}, {31'b0, !mfull[i]});
        if (!mfull[i]) begin
            set_txd(i, w);
            txv[i] = 1'b1;
            tick(1);
            txv[i] = 1'b0;
            mbuf[i]  = mask(i, w);
            mfull[i] = 1'b1;
            tick(1);
            chk("tx_ready_full", {31'b0, txr[i]}, 32'h0);
        end
    endtask

    // Host side of nbits bit-times; optionally offers rw exactly in the cycle of the first load.
    task automatic xfer_bits(input int i, input logic [31:0] w, input int nbits,
                             input bit race, input logic [31:0] rw, output logic [31:0] r);
        r = '0;
        for (int b = 0; b < nbits; b++) begin
            int pos;
            pos = MSB_OF[i] ? (W_OF[i] - 1 - b) : b;
            if (!CPHA_OF[i]) begin
                mosi = w[pos];
                tick(HALF);
                r[pos]  = miso[i];
                sclk[i] = !CPOL_OF[i];
                tick(HALF);
                sclk[i] = CPOL_OF[i];
            end else begin
                sclk[i] = !CPOL_OF[i];
                mosi    = w[pos];
                if (race && b == 0) begin
                    tick(2);
                    set_txd(i, rw);
                    txv[i] = 1'b1;
                    tick(1);
                    chk("underrun_same_cycle", {31'b0, und[i]}, 32'h1);
                    txv[i] = 1'b0;
                    tick(HALF - 3);
                end else begin
                    tick(HALF);
                end
                r[pos]  = miso[i];
                sclk[i] = CPOL_OF[i];
                tick(HALF);
            end
        end
        if (!CPHA_OF[i]) tick(HALF);
    endtask

    task automatic ss_low(input int i);
        ss[i] = 1'b0;
        if (!CPHA_OF[i]) model_load(i, pend[i]);
        tick(HALF);
        chk("busy_active", {31'b0, bsy[i]}, 32'h1);
    endtask

    task automatic ss_high(input int i);
        tick(HALF);
        ss[i] = 1'b1;
        tick(2 * HALF);
        chk("busy_idle", {31'b0, bsy[i]}, 32'h0);
        chk("miso_idle", {31'b0, miso[i]}, 32'h0);
        chk("underrun_count", 32'(und_cnt[i]), 32'(exp_und[i]));
    endtask

    task automatic do_word(input int i, input logic [31:0] w, input bit race, input logic [31:0] rw);
        logic [31:0] exp_tx, got;
        int n0;
        n0 = rx_n;
        if (CPHA_OF[i]) model_load(i, exp_tx);
        else exp_tx = pend[i];
        if (race) begin
            mbuf[i]  = mask(i, rw);
            mfull[i] = 1'b1;
        end
        xfer_bits(i, w, W_OF[i], race, rw, got);
        chk("miso_word", got, exp_tx);
        chk("rx_valid_pulses", 32'(rx_n - n0), 32'h1);
        chk("rx_data", rxd_of(i), mask(i, w));
        chk("rx_data_at_pulse", rx_at_pulse, mask(i, w));
        last_rx[i] = mask(i, w);
        if (!CPHA_OF[i]) model_load(i, pend[i]);
    endtask

    initial begin
        logic [31:0] got, w, exp_tx;
        int n0, iw, nw;

        rst  = 1'b1;
        mosi = 1'b0;
        txd0 = '0; txd1 = '0; txd2 = '0;
        for (int i = 0; i < N; i++) begin
            sclk[i]    = CPOL_OF[i];
            ss[i]      = 1'b1;
            txv[i]     = 1'b0;
            exp_und[i] = 0;
            pend[i]    = '0;
            mbuf[i]    = '0;
        end
        model_reset();
        tick(4);
        for (int i = 0; i < N; i++) begin
            chk("rst_rx_data", rxd_of(i), 32'h0);
            chk("rst_rx_valid", {31'b0, rxv[i]}, 32'h0);
            chk("rst_tx_ready", {31'b0, txr[i]}, 32'h1);
            chk("rst_underrun", {31'b0, und[i]}, 32'h0);
            chk("rst_busy", {31'b0, bsy[i]}, 32'h0);
            chk("rst_miso", {31'b0, miso[i]}, 32'h0);
        end
        rst = 1'b0;
        tick(10);

        // Mode 0, preloaded 0x3C, host sends 0xA5.
        offer(0, 32'h3C);
        ss_low(0);
        chk("tx_ready_after_load", {31'b0, txr[0]}, 32'h1);
        do_word(0, 32'hA5, 1'b0, '0);
        ss_high(0);

        // Mode 3, 16-bit LSB first, two back-to-back words with refill.
        offer(1, 32'h1234);
        ss_low(1);
        do_word(1, 32'h1234, 1'b0, '0);
        offer(1, 32'hBEEF);
        do_word(1, 32'hBEEF, 1'b0, '0);
        ss_high(1);

        // Mode 1, empty buffer at frame start, word offered mid-frame.
        ss_low(2);
        do_word(2, $urandom, 1'b0, '0);
        offer(2, 32'h96);
        do_word(2, $urandom, 1'b0, '0);
        ss_high(2);

        // SS released after 5 of 8 bits, then a full frame.
        offer(0, $urandom);
        ss_low(0);
        exp_tx = pend[0];
        n0 = rx_n;
        xfer_bits(0, $urandom, 5, 1'b0, '0, got);
        ss_high(0);
        chk("partial_miso", got >> 3, exp_tx >> 3);
        chk("partial_no_rx_valid", 32'(rx_n - n0), 32'h0);
        chk("partial_rx_hold", rxd_of(0), last_rx[0]);
        offer(0, $urandom);
        ss_low(0);
        do_word(0, $urandom, 1'b0, '0);
        ss_high(0);

        // Reset mid-frame with SS held low.
        offer(0, $urandom);
        ss_low(0);
        xfer_bits(0, $urandom, 3, 1'b0, '0, got);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        model_reset();
        tick(1);
        chk("midrst_busy", {31'b0, bsy[0]}, 32'h0);
        chk("midrst_rx_data", rxd_of(0), 32'h0);
        chk("midrst_tx_ready", {31'b0, txr[0]}, 32'h1);
        chk("midrst_miso", {31'b0, miso[0]}, 32'h0);
        n0 = rx_n;
        xfer_bits(0, $urandom, 8, 1'b0, '0, got);
        chk("midrst_ignored_rx", 32'(rx_n - n0), 32'h0);
        chk("midrst_still_idle", {31'b0, bsy[0]}, 32'h0);
        chk("midrst_miso_quiet", got, 32'h0);
        ss_high(0);
        offer(0, $urandom);
        ss_low(0);
        do_word(0, $urandom, 1'b0, '0);
        ss_high(0);

        // tx_valid lands in the load cycle of an empty buffer.
        ss_low(2);
        w = $urandom;
        do_word(2, $urandom, 1'b1, w);
        do_word(2, $urandom, 1'b0, '0);
        ss_high(2);

        // Randomised frames across all instances.
        for (int k = 0; k < 6; k++) begin
            iw = int'($urandom_range(0, N - 1));
            nw = int'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) offer(iw, $urandom);
            ss_low(iw);
            for (int j = 0; j < nw; j++) begin
                if ($urandom_range(0, 1) == 1) offer(iw, $urandom);
                do_word(iw, $urandom, 1'b0, '0);
            end
            ss_high(iw);
        end

        for (int i = 0; i < N; i++) begin
            chk("final_underruns", 32'(und_cnt[i]), 32'(exp_und[i]));
            chk("final_rx_data", rxd_of(i), last_rx[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
